i2s_serializer: RTL and testbench
=================================

I2S_SERIALIZER -- requirements
Module: i2s_serializer

Interface
REQ-001 Parameter DATA_W, default 24: sample width per channel, in bits.
REQ-002 Parameter SLOT_W, default 32: bclk periods per channel slot; SHALL be at least DATA_W, and at least DATA_W+1 when MODE=0 (elaboration error otherwise).
REQ-003 Parameter BCLK_DIV, default 4: clk_12M cycles per bclk period; SHALL be even and at least 2.
REQ-004 Parameter MODE, default 0: 0 = I2S (MSB one bclk after the lrclk edge), 1 = left-justified (MSB on the lrclk edge).
REQ-005 clk_12M  in  1  sole clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  run request; frames are generated while it is high.
REQ-008 in_valid  in  1  data_left/data_right hold a valid stereo sample.
REQ-009 in_ready  out  1  the holding register is empty and can accept a sample.
REQ-010 data_left  in  DATA_W  left sample, two's complement.
REQ-011 data_right  in  DATA_W  right sample, two's complement.
REQ-012 data_serial  out  1  serial data, MSB first.
REQ-013 bclk  out  1  bit clock.
REQ-014 lrclk  out  1  word select; 0 = left slot, 1 = right slot.
REQ-015 clk_fsample  out  1  one-cycle pulse at each frame start.
REQ-016 underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Divider div_cnt counts 0..BCLK_DIV-1; bclk SHALL be 0 for div_cnt < BCLK_DIV/2 and 1 otherwise, so a falling edge occurs at each div_cnt wrap to 0.
REQ-019 Bit counter b counts 0..2*SLOT_W-1; it SHALL increment at each bclk falling edge and wrap to 0 at the end of the frame.
REQ-020 lrclk SHALL be 1 when b >= SLOT_W and 0 otherwise, in both modes.
REQ-021 Slot position p: MODE=1 gives p = b mod SLOT_W; MODE=0 gives p = (b-1) mod SLOT_W, where b=0 maps to p = SLOT_W-1.
REQ-022 data_serial SHALL be sample[DATA_W-1-p] when p < DATA_W and 0 otherwise; sample is the left word when the slot is left and the right word otherwise.
REQ-023 data_serial SHALL change only on bclk falling edges and be stable across each rising edge.
REQ-024 Handshake: a transfer occurs on a cycle with in_valid && in_ready; the transfer captures both words into the holding register and clears in_ready on the next cycle.
REQ-025 Frame start is the cycle where b=0 and div_cnt=0.
REQ-026 At frame start, clk_fsample SHALL pulse high for one cycle and the shift register SHALL load:
  - holding register full: load its contents, then holding becomes empty and in_ready returns to 1 on the next cycle;
  - holding register empty: load zeros and pulse underrun.
REQ-027 A transfer and a frame-start load in the same cycle: the load takes the old holding contents, the new sample is held, and in_ready stays 0.
REQ-028 Idle state (IDLE): counters at 0, bclk=0, lrclk=0, data_serial=0, no pulses; the handshake SHALL remain operational so one sample can be preloaded.
REQ-029 IDLE->RUN when enable=1; the first frame start occurs on the next cycle.
REQ-030 enable falling mid-frame: the block SHALL complete the current frame, then enter IDLE at the next frame boundary without issuing a clk_fsample pulse.
REQ-031 Latency: the MSB of a sample loaded at frame start appears on data_serial in that cycle (MODE=1), or one bclk period later (MODE=0).

Reset
REQ-032 While rst=1: bclk=0, lrclk=0, data_serial=0, clk_fsample=0, underrun=0, in_ready=1; holding register empty; all counters 0; state IDLE.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately and discard any held sample; rst has priority over enable and in_valid.

Verification
REQ-034 Defaults, preload L=24'haaafaa / R=24'h123456, then enable=1 -> bclk period 4 cycles, frame 256 cycles, clk_fsample every 256 cycles; left bits start one bclk after lrclk falls; bits 24..31 of each slot are 0; no underrun.
REQ-035 MODE=1, same data -> MSB 1 appears in the frame-start cycle, aligned with the lrclk edge.
REQ-036 enable=1 with no sample supplied -> underrun pulses and data_serial=0 for every frame; in_ready stays 1.
REQ-037 in_valid held high with incrementing data -> exactly one transfer per frame, in_ready low between transfers, samples output in order with none dropped.
REQ-038 enable dropped at b=10 -> frame finishes, outputs return to 0 and no further clk_fsample pulses occur.
REQ-039 rst pulsed at b=40 -> all outputs take their reset values on the next cycle; after rst, re-enabling gives a clean frame starting at b=0.

Source files
------------

// File: rtl/i2s_serializer.sv
// I2S / left-justified stereo serializer with a one-sample holding register.
// Outputs are registered from next-state values so they line up with the counters they describe.
module i2s_serializer #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4,
    parameter int MODE     = 0
) (
    input  logic              clk_12M,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_left,
    input  logic [DATA_W-1:0] data_right,
    output logic              data_serial,
    output logic              bclk,
    output logic              lrclk,
    output logic              clk_fsample,
    output logic              underrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int B_W   = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
    localparam logic [B_W-1:0]   SLOT_B   = B_W'(SLOT_W);
    localparam logic [B_W-1:0]   DATA_B   = B_W'(DATA_W);

    if (SLOT_W < DATA_W + ((MODE == 0) ? 1 : 0)) begin : g_bad_slot
        $error("i2s_serializer: SLOT_W too small for DATA_W and MODE");
    end
    if ((BCLK_DIV < 2) || (BCLK_DIV % 2 != 0)) begin : g_bad_div
        $error("i2s_serializer: BCLK_DIV must be even and at least 2");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt, div_nx;
    logic [B_W-1:0]     b, b_nx;
    logic [DATA_W-1:0]  hold_l, hold_r, hold_l_nx, hold_r_nx;
    logic [DATA_W-1:0]  frame_l, frame_r, frame_l_nx, frame_r_nx;
    logic               hold_full, hold_full_nx;
    logic               start_nx, underrun_nx, bit_nx, xfer;
    logic [B_W-1:0]     pos, p;
    logic [DATA_W-1:0]  word_sh;

    // Frame sequencing: IDLE starts a frame immediately; a frame wrap only restarts if enable is still high.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        b_nx     = b;
        start_nx = 1'b0;
        case (state)
            IDLE: begin
                div_nx = '0;
                b_nx   = '0;
                if (enable) begin
                    state_nx = RUN;
                    start_nx = 1'b1;
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    if (b == B_LAST) begin
                        b_nx = '0;
                        if (enable) start_nx = 1'b1;
                        else        state_nx = IDLE;
                    end else begin
                        b_nx = b + B_W'(1);
                    end
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The frame load consumes the old holding contents first, so a simultaneous transfer is kept for the next frame.
    always_comb begin
        xfer         = in_valid && in_ready;
        hold_l_nx    = hold_l;
        hold_r_nx    = hold_r;
        hold_full_nx = hold_full;
        frame_l_nx   = frame_l;
        frame_r_nx   = frame_r;
        underrun_nx  = 1'b0;
        if (start_nx) begin
            frame_l_nx   = hold_full ? hold_l : '0;
            frame_r_nx   = hold_full ? hold_r : '0;
            underrun_nx  = !hold_full;
            hold_full_nx = 1'b0;
        end
        if (xfer) begin
            hold_l_nx    = data_left;
            hold_r_nx    = data_right;
            hold_full_nx = 1'b1;
        end

        if (MODE == 0) pos = (b_nx == '0) ? B_LAST : b_nx - B_W'(1);
        else           pos = b_nx;
        p       = (pos >= SLOT_B) ? pos - SLOT_B : pos;
        word_sh = ((b_nx >= SLOT_B) ? frame_r_nx : frame_l_nx) << p;
        bit_nx  = 1'b0;
        if ((state_nx == RUN) && (p < DATA_B)) bit_nx = word_sh[DATA_W-1];
    end

    always_ff @(posedge clk_12M) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            b           <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            hold_full   <= 1'b0;
            frame_l     <= '0;
            frame_r     <= '0;
            in_ready    <= 1'b1;
            data_serial <= 1'b0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            clk_fsample <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            div_cnt     <= div_nx;
            b           <= b_nx;
            hold_l      <= hold_l_nx;
            hold_r      <= hold_r_nx;
            hold_full   <= hold_full_nx;
            frame_l     <= frame_l_nx;
            frame_r     <= frame_r_nx;
            in_ready    <= !hold_full_nx;
            data_serial <= bit_nx;
            bclk        <= (state_nx == RUN) && (div_nx >= DIV_HALF);
            lrclk       <= (b_nx >= SLOT_B);
            clk_fsample <= start_nx;
            underrun    <= underrun_nx;
        end
    end

endmodule

// File: tb/tb_i2s_serializer.sv
// Runs an I2S and a left-justified serializer side by side against a cycle-indexed frame model.
module tb_i2s_serializer;

    localparam int DATA_W   = 24;
    localparam int SLOT_W   = 32;
    localparam int BCLK_DIV = 4;
    localparam int FRAME    = 2 * SLOT_W * BCLK_DIV;

    logic clk_12M = 1'b0;
    logic rst = 1'b1, enable = 1'b0, in_valid = 1'b0;
    logic [DATA_W-1:0] data_left = '0, data_right = '0;
    logic ready_a, ser_a, bclk_a, lr_a, fs_a, ur_a;
    logic ready_b, ser_b, bclk_b, lr_b, fs_b, ur_b;

    always #5 clk_12M = ~clk_12M;

    i2s_serializer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(0)) dut_i2s (
        .clk_12M(clk_12M), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ready_a),
        .data_left(data_left), .data_right(data_right), .data_serial(ser_a), .bclk(bclk_a),
        .lrclk(lr_a), .clk_fsample(fs_a), .underrun(ur_a));

    i2s_serializer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(1)) dut_lj (
        .clk_12M(clk_12M), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(ready_b),
        .data_left(data_left), .data_right(data_right), .data_serial(ser_b), .bclk(bclk_b),
        .lrclk(lr_b), .clk_fsample(fs_b), .underrun(ur_b));

    // Model state: running flag, cycle index inside the frame, holding register and current frame words.
    bit m_run, m_hold_full, m_fs, m_ur, m_xfer;
    int m_t;
    logic [DATA_W-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
    int checks = 0, passes = 0;
    int fs_seen = 0, fs_model = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v);
        rst      = r;
        enable   = e;
        in_valid = v;
    endtask

    function automatic logic expBit(input int mode);
        int bitn, p;
        logic [DATA_W-1:0] word;
        bitn = m_t / BCLK_DIV;
        p    = (mode == 1) ? bitn % SLOT_W : (bitn + SLOT_W - 1) % SLOT_W;
        word = (bitn >= SLOT_W) ? m_cur_r : m_cur_l;
        if (p >= DATA_W) return 1'b0;
        return word[DATA_W-1-p];
    endfunction

    // {in_ready, data_serial, bclk, lrclk, clk_fsample, underrun}
    function automatic logic [5:0] expOut(input int mode);
        if (!m_run) return {!m_hold_full, 5'b0};
        return {!m_hold_full, expBit(mode), (m_t % BCLK_DIV) >= BCLK_DIV / 2,
                (m_t / BCLK_DIV) >= SLOT_W, m_fs, m_ur};
    endfunction

    task automatic modelStep();
        bit start;
        start  = 1'b0;
        m_xfer = 1'b0;
        if (rst) begin
            m_run = 0; m_t = 0; m_hold_full = 0; m_fs = 0; m_ur = 0;
            m_cur_l = '0; m_cur_r = '0;
        end else begin
            m_xfer = in_valid && !m_hold_full;
            if (!m_run) begin
                if (enable) begin m_run = 1; m_t = 0; start = 1; end
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_t = 0;
                    if (enable) start = 1;
                    else        m_run = 0;
                end
            end
            m_ur = 0;
            if (start) begin
                m_cur_l     = m_hold_full ? m_hold_l : '0;
                m_cur_r     = m_hold_full ? m_hold_r : '0;
                m_ur        = !m_hold_full;
                m_hold_full = 0;
                fs_model++;
            end
            if (m_xfer) begin
                m_hold_l = data_left; m_hold_r = data_right; m_hold_full = 1;
            end
            m_fs = start;
        end
    endtask

    task automatic tick();
        @(posedge clk_12M);
        modelStep();
        #1;
        if (fs_a) fs_seen++;
        checkOutput("i2s outputs", {26'd0, ready_a, ser_a, bclk_a, lr_a, fs_a, ur_a}, {26'd0, expOut(0)});
        checkOutput("lj outputs",  {26'd0, ready_b, ser_b, bclk_b, lr_b, fs_b, ur_b}, {26'd0, expOut(1)});
    endtask

    initial begin
        applyStimulus(1, 0, 0);
        repeat (3) tick();

        // Preload one sample while idle, then run: one good frame followed by underruns.
        data_left  = 24'haaafaa;
        data_right = 24'h123456;
        applyStimulus(0, 0, 1);
        tick();
        applyStimulus(0, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 1, 0);
        repeat (3 * FRAME) tick();

        // Continuous streaming of incrementing samples.
        data_left  = DATA_W'($urandom);
        data_right = DATA_W'($urandom);
        applyStimulus(0, 1, 1);
        repeat (4 * FRAME) begin
            tick();
            if (m_xfer) begin
                data_left++;
                data_right++;
            end
        end
        applyStimulus(0, 1, 0);

        // Drop enable at bit 10 and let the frame drain.
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (m_run && m_t == 10 * BCLK_DIV) break;
        end
        applyStimulus(0, 0, 0);
        repeat (2 * FRAME) tick();

        // Random handshake traffic.
        applyStimulus(0, 1, 0);
        repeat (3 * FRAME) begin
            data_left  = DATA_W'($urandom);
            data_right = DATA_W'($urandom);
            in_valid   = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Reset pulse at bit 40 with a sample held, then a clean restart.
        in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (m_run && m_t == 40 * BCLK_DIV) break;
        end
        applyStimulus(1, 1, 1);
        tick();
        applyStimulus(0, 0, 0);
        repeat (4) tick();
        data_left  = DATA_W'($urandom);
        data_right = DATA_W'($urandom);
        applyStimulus(0, 0, 1);
        tick();
        applyStimulus(0, 1, 0);
        repeat (2 * FRAME) tick();

        checkOutput("fsample count", 32'(fs_seen), 32'(fs_model));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
